cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Run/step clock controller that sits directly upstream of the CPU top level and produces the CPU clock it consumes. It debounces the board run switch and step button, divides the board clock to a selectable fast or slow CPU rate, and supports single-step operation. It stops the CPU cleanly on a halt request from the pipeline. An optional counter of issued CPU clock edges is provided for the statistics display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable `clk` cycles required before a debounced input changes.
- FAST_HALF, 2: `clk` cycles per CPU half-period when `changef`=0; must be ≥1.
- SLOW_HALF, 25000000: `clk` cycles per CPU half-period when `changef`=1; must be ≥1.

Ports:
- clk  in  1  board clock; all logic is rising-edge.
- in_RST  in  1  reset, asynchronous, active-high.
- run_sw  in  1  raw run switch (asynchronous); 1 = free-run.
- step_btn  in  1  raw step button (asynchronous); each debounced press gives one CPU cycle.
- changef  in  1  speed select; 0 = FAST_HALF, 1 = SLOW_HALF.
- halt  in  1  halt request from the CPU (syscall exit); synchronous to `clk`.
- cpu_clk  out  1  CPU clock; idles high; a CPU cycle is low then high.
- running  out  1  1 while in RUN.
- halted  out  1  1 while in HALT.
- edge_count  out  32  number of `cpu_clk` rising edges issued.

## Operation
- Input conditioning: `run_sw` and `step_btn` each pass through a 2-FF synchronizer and then a debounce counter. The debounced value updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. A step press is a 0→1 edge of debounced step.
- The half-period counter reloads from `changef` at each reload point: HALF = changef ? SLOW_HALF : FAST_HALF. A change of `changef` mid half-period takes effect at the next reload.
- FSM states:
  - IDLE (reset state): `cpu_clk`=1.
    - Go to HALT if `halt`=1.
    - Otherwise go to RUN if debounced run=1.
    - Otherwise go to STEP_LO on a step press.
    - Run has priority over step in the same cycle.
  - RUN: `cpu_clk` toggles every HALF cycles, starting with a fall in the first RUN cycle. At each rising edge of `cpu_clk`, go to HALT if `halt`=1, else go to IDLE if debounced run=0, else continue. If run drops while `cpu_clk` is low, the low phase completes; the cycle is never truncated. Step presses are ignored.
  - STEP_LO: `cpu_clk`=0 for exactly HALF cycles, then rises. On the rise, go to HALT if `halt`=1, else go to IDLE.
  - HALT: `cpu_clk`=1, frozen. Only `in_RST` exits this state.
- `edge_count` increments by 1 in the cycle `cpu_clk` rises. It wraps from 0xFFFFFFFF to 0.
- Reset values: `cpu_clk`=1, `running`=0, `halted`=0, `edge_count`=0. Debounced values, synchronizers and counters reset to 0, and the state resets to IDLE. Reset mid-cycle forces `cpu_clk` high immediately (asynchronous); no partial cycle is counted.

## Timing
- All outputs are registered; none are combinational from inputs.
- Raw input to debounced change: 2 + DEBOUNCE_CYCLES `clk` cycles.
- Step: the debounced press is registered in cycle N. `cpu_clk` falls at N+1, stays low HALF cycles, and rises at N+1+HALF. `edge_count` updates on the same edge.
- RUN: `cpu_clk` period = 2×HALF `clk` cycles, 50% duty.
- `running`/`halted` change on the same edge as the state register.
- `halt` is sampled only at IDLE cycles and at `cpu_clk` rising points. A halt pulse outside those points is not captured.

## Configuration
- CPU_CLK_CTRL_EDGE_COUNT_EN: when defined, the 32-bit `edge_count` register is implemented as described. When undefined, the counter is not built and `edge_count` is constant 0.
- The FSM and `cpu_clk` behaviour are identical either way.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, FAST_HALF=2, SLOW_HALF=5, with macro defined unless stated.

- Reset, then hold step_btn=1 for 10 cycles, then release → exactly one `cpu_clk` low pulse 2 cycles wide; `edge_count`=1; state back to IDLE.
- step_btn glitches (1 for 3 cycles, 0 for 1, repeated 5 times) → no `cpu_clk` fall; `edge_count`=0.
- run_sw=1, `changef`=0 held 40 cycles → period 4 cycles, `running`=1. Switch `changef`=1 mid-run → period becomes 10 at the next reload. Drop run_sw while `cpu_clk` is low → low phase completes, ends high, `running`=0.
- Running; assert `halt` for the cycle of a `cpu_clk` rise → `halted`=1, `cpu_clk` stays 1, `edge_count` frozen. Step and run are ignored until `in_RST`, after which `halted`=0.
- Assert `in_RST` asynchronously while `cpu_clk`=0 in STEP_LO → `cpu_clk`=1 immediately; `edge_count`=0; IDLE.
- Macro undefined: 5 step presses → 5 `cpu_clk` pulses; `edge_count` stays 0.

Source files
------------

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board-side controls and the CPU clock controller.
// master = board/test side driving the controls, slave = cpu_clk_ctrl.
interface cpu_clk_ctrl_if;
    logic        run_sw;
    logic        step_btn;
    logic        changef;
    logic        halt;
    logic        cpu_clk;
    logic        running;
    logic        halted;
    logic [31:0] edge_count;

    modport master (
        output run_sw, step_btn, changef, halt,
        input  cpu_clk, running, halted, edge_count
    );

    modport slave (
        input  run_sw, step_btn, changef, halt,
        output cpu_clk, running, halted, edge_count
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/step CPU clock generator: debounced run/step controls, fast/slow divider, halt stop.
// Optional CPU_CLK_CTRL_EDGE_COUNT_EN builds the 32-bit cpu_clk rising-edge counter.
module cpu_clk_ctrl_deb #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);
    logic        s1, s2;
    logic [31:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // any return to the settled value restarts the stability window
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == 32'(CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
endmodule

module cpu_clk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FAST_HALF       = 2,
    parameter int SLOW_HALF       = 25000000
) (
    input  logic          clk,
    input  logic          in_RST,
    cpu_clk_ctrl_if.slave bus
);
    localparam int NUM_IN = 2;

    typedef enum logic [1:0] {IDLE, RUN, STEP_LO, HALT} state_t;

    state_t              state;
    logic [NUM_IN-1:0]   raw_vec, deb_vec;
    logic                deb_run, deb_step, step_prev, press;
    logic                cpu_q, running_q, halted_q;
    logic [31:0]         half_cnt, reload, edge_cnt;
    logic                tick_done, rise_evt;

    assign raw_vec = {bus.step_btn, bus.run_sw};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        cpu_clk_ctrl_deb #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk (clk),
            .rst (in_RST),
            .raw (raw_vec[i]),
            .deb (deb_vec[i])
        );
    end

    assign deb_run  = deb_vec[0];
    assign deb_step = deb_vec[1];
    assign press    = deb_step & ~step_prev;

    // speed select is only consulted when the half-period counter reloads
    assign reload    = bus.changef ? 32'(SLOW_HALF - 1) : 32'(FAST_HALF - 1);
    assign tick_done = (half_cnt == '0);
    assign rise_evt  = ((state == RUN) || (state == STEP_LO)) && !cpu_q && tick_done;

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            state     <= IDLE;
            cpu_q     <= 1'b1;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            half_cnt  <= '0;
            step_prev <= 1'b0;
        end else begin
            step_prev <= deb_step;
            case (state)
                IDLE: begin
                    if (bus.halt) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (deb_run) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                        cpu_q     <= 1'b0;
                        half_cnt  <= reload;
                    end else if (press) begin
                        state    <= STEP_LO;
                        cpu_q    <= 1'b0;
                        half_cnt <= reload;
                    end
                end
                RUN: begin
                    if (tick_done) begin
                        half_cnt <= reload;
                        cpu_q    <= ~cpu_q;
                        // exits are only taken on a rise so no cycle is cut short
                        if (rise_evt) begin
                            if (bus.halt) begin
                                state     <= HALT;
                                running_q <= 1'b0;
                                halted_q  <= 1'b1;
                            end else if (!deb_run) begin
                                state     <= IDLE;
                                running_q <= 1'b0;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt - 32'd1;
                    end
                end
                STEP_LO: begin
                    if (rise_evt) begin
                        cpu_q    <= 1'b1;
                        state    <= bus.halt ? HALT : IDLE;
                        halted_q <= bus.halt;
                    end else begin
                        half_cnt <= half_cnt - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_CLK_CTRL_EDGE_COUNT_EN
    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST)        edge_cnt <= '0;
        else if (rise_evt) edge_cnt <= edge_cnt + 32'd1;
    end
`else
    assign edge_cnt = '0;
`endif

    assign bus.cpu_clk    = cpu_q;
    assign bus.running    = running_q;
    assign bus.halted     = halted_q;
    assign bus.edge_count = edge_cnt;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: step vector table plus run, halt and async-reset sequences.
module tb_cpu_clk_ctrl;
    logic clk = 1'b0;
    logic in_RST;

    cpu_clk_ctrl_if bif ();

    cpu_clk_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .FAST_HALF       (2),
        .SLOW_HALF       (5)
    ) dut (
        .clk    (clk),
        .in_RST (in_RST),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    on_c;
        int    off_c;
        int    reps;
        bit    chf;
        int    exp_rises;
        int    exp_low;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // cpu_clk observer, sampled on the falling board edge
    int   cyc = 0, falls = 0, rises = 0;
    int   last_fall = 0, period = 0, low_len = 0, last_low = 0;
    logic prev_cpu = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_cpu && !bif.cpu_clk) begin
            falls     = falls + 1;
            period    = cyc - last_fall;
            last_fall = cyc;
            low_len   = 0;
        end
        if (!bif.cpu_clk) low_len = low_len + 1;
        if (!prev_cpu && bif.cpu_clk) begin
            rises    = rises + 1;
            last_low = low_len;
        end
        prev_cpu = bif.cpu_clk;
    end

    function automatic logic [31:0] exp_ec(int n);
`ifdef CPU_CLK_CTRL_EDGE_COUNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_cpu(input logic val, input int maxc, input string name);
        int k;
        k = 0;
        while (bif.cpu_clk !== val && k < maxc) begin
            cycles(1);
            k++;
        end
        chk(name, 32'(bif.cpu_clk), 32'(val));
    endtask

    task automatic do_reset();
        in_RST = 1'b1;
        cycles(2);
        in_RST = 1'b0;
        cycles(1);
    endtask

    vec_t vecs[4];
    int   exp_edges, r0, f0, base;
    logic [31:0] ec_hold;

    initial begin
        vecs[0] = '{"step_fast", 10, 15, 1, 1'b0, 1, 2};
        vecs[1] = '{"step_slow", 10, 15, 1, 1'b1, 1, 5};
        vecs[2] = '{"glitch",     3,  1, 5, 1'b0, 0, 0};
        vecs[3] = '{"step_x3",    8, 12, 3, 1'b0, 3, 2};

        in_RST       = 1'b1;
        bif.run_sw   = 1'b0;
        bif.step_btn = 1'b0;
        bif.changef  = 1'b0;
        bif.halt     = 1'b0;
        cycles(3);
        chk("rst_cpu_clk", 32'(bif.cpu_clk), 32'd1);
        chk("rst_running", 32'(bif.running), 32'd0);
        chk("rst_halted",  32'(bif.halted),  32'd0);
        chk("rst_edges",   bif.edge_count,   32'd0);
        in_RST = 1'b0;
        cycles(2);

        exp_edges = 0;
        for (int i = 0; i < 4; i++) begin
            r0 = rises;
            bif.changef = vecs[i].chf;
            for (int r = 0; r < vecs[i].reps; r++) begin
                bif.step_btn = 1'b1;
                cycles(vecs[i].on_c);
                bif.step_btn = 1'b0;
                cycles(vecs[i].off_c);
            end
            cycles(10);
            exp_edges += vecs[i].exp_rises;
            chk({vecs[i].name, "_rises"}, 32'(rises - r0), 32'(vecs[i].exp_rises));
            if (vecs[i].exp_rises > 0)
                chk({vecs[i].name, "_low"}, 32'(last_low), 32'(vecs[i].exp_low));
            chk({vecs[i].name, "_cpu"},   32'(bif.cpu_clk), 32'd1);
            chk({vecs[i].name, "_idle"},  32'({bif.running, bif.halted}), 32'd0);
            chk({vecs[i].name, "_edges"}, bif.edge_count, exp_ec(exp_edges));
        end

        // free run, speed change, then drop run during a low phase
        bif.changef = 1'b0;
        bif.run_sw  = 1'b1;
        cycles(40);
        chk("run_running", 32'(bif.running), 32'd1);
        chk("run_fast_period", 32'(period), 32'd4);
        bif.changef = 1'b1;
        cycles(40);
        chk("run_slow_period", 32'(period), 32'd10);
        wait_cpu(1'b0, 20, "run_find_low");
        bif.run_sw = 1'b0;
        cycles(40);
        chk("run_stop_cpu", 32'(bif.cpu_clk), 32'd1);
        chk("run_stop_running", 32'(bif.running), 32'd0);
        chk("run_stop_full_low", 32'(last_low), 32'd5);
        f0 = falls;
        cycles(12);
        chk("run_stop_quiet", 32'(falls - f0), 32'd0);
        bif.changef = 1'b0;

        // halt captured at a rising cpu_clk point
        do_reset();
        base = rises;
        bif.run_sw = 1'b1;
        cycles(20);
        wait_cpu(1'b0, 10, "halt_find_low");
        bif.halt = 1'b1;
        wait_cpu(1'b1, 10, "halt_find_rise");
        bif.halt = 1'b0;
        chk("halt_halted",  32'(bif.halted),  32'd1);
        chk("halt_running", 32'(bif.running), 32'd0);
        chk("halt_edges",   bif.edge_count, exp_ec(rises - base));
        ec_hold = bif.edge_count;
        f0 = falls;
        bif.step_btn = 1'b1;
        cycles(30);
        chk("halt_frozen_falls", 32'(falls - f0), 32'd0);
        chk("halt_frozen_cpu",   32'(bif.cpu_clk), 32'd1);
        chk("halt_frozen_edges", bif.edge_count, ec_hold);
        chk("halt_sticky",       32'(bif.halted), 32'd1);
        bif.step_btn = 1'b0;
        do_reset();
        chk("halt_cleared", 32'(bif.halted), 32'd0);
        chk("halt_rst_edges", bif.edge_count, 32'd0);
        bif.run_sw = 1'b0;
        cycles(15);

        // asynchronous reset while a step pulse is low
        bif.changef  = 1'b1;
        bif.step_btn = 1'b1;
        wait_cpu(1'b0, 20, "arst_find_low");
        bif.step_btn = 1'b0;
        #2 in_RST = 1'b1;
        #1;
        chk("arst_cpu_high", 32'(bif.cpu_clk), 32'd1);
        chk("arst_edges", bif.edge_count, 32'd0);
        cycles(1);
        in_RST = 1'b0;
        f0 = falls;
        cycles(15);
        chk("arst_idle_falls", 32'(falls - f0), 32'd0);
        chk("arst_idle_state", 32'({bif.running, bif.halted, bif.cpu_clk}), 32'd1);
        chk("arst_idle_edges", bif.edge_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
